// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL layout, MODE and FSM encodings, and the bus windows of both instances.
package timer_dev_pkg;

    // Word offsets inside a 16-byte window (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_UNUSED = 2'd3;

    // CTRL bit positions; the packed struct below uses the same layout
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_BITS     = 4;

    // System bridge windows of the two timer instances
    localparam logic [15:0] TIMER0_BASE = 16'h7f00;
    localparam logic [15:0] TIMER1_BASE = 16'h7f10;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    typedef struct packed {
        logic  im;
        mode_e mode;
        logic  en;
    } ctrl_t;

    // Only MODE 1 reloads; the reserved encodings fall back to one-shot
    function automatic logic is_reload(input ctrl_t c);
        return c.mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer with one-shot / auto-reload modes and a
// maskable interrupt; one FSM plus the CTRL/PRESET/COUNT register file.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    ctrl_t            ctrl_q,    ctrl_d;
    logic [WIDTH-1:0] preset_q,  preset_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic             pending_q, pending_d;
    state_e           state_q,   state_d;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;
        state_d   = state_q;

        if (ctrl_wr || preset_wr) begin
            pending_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // A preset of 0 terminates here exactly like a preset of 1
                    count_d   = '0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    pending_d = 1'b0;
                    state_d   = ctrl_q.en ? ST_LOAD : ST_IDLE;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CPU write to CTRL overrides the FSM's own EN clear in the same cycle
        if (ctrl_wr) begin
            ctrl_d = ctrl_t'(wdata[CTRL_BITS-1:0]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    assign irq = pending_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized scenario bench for timer_dev; expected values come from a
// timeline model of the countdown (cycles since the enabling write).
module tb_timer_dev;
    import timer_dev_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    timer_dev #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [WIDTH-1:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    // ---------------- reference model ----------------
    // A preset of 0 takes as long as a preset of 1
    function automatic int eff(input logic [WIDTH-1:0] n);
        return (n == 0) ? 1 : int'(n);
    endfunction

    // COUNT j edges after the edge on which PRESET is loaded
    function automatic logic [WIDTH-1:0] run_count(input logic [WIDTH-1:0] n, input int j);
        if (j == 0) return n;
        if (j >= eff(n)) return '0;
        return WIDTH'(eff(n) - j);
    endfunction

    // Brings the timer to a stopped, idle state with nothing pending
    task automatic quiesce();
        wr(ADDR_CTRL, '0);
        repeat (4) tick();
        wr(ADDR_CTRL, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [WIDTH-1:0] v;
        int t0;
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL reset_reg%0d: got %0h expected 0", a, v); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        tick();

        // Reset in the middle of a countdown at COUNT=5
        wr(ADDR_PRESET, 20);
        wr(ADDR_CTRL, 32'h9);
        t0 = cyc;
        while (cyc < t0 + 17) tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== run_count(20, 15)) begin bad++; $display("FAIL midcount_pre: got %0d expected %0d", v, run_count(20, 15)); end
        #2 reset = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL midreset_reg%0d: got %0h expected 0", a, v); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b expected 0", irq); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL postreset_count: got %0d expected 0", v); end
        rd(ADDR_CTRL, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL postreset_ctrl: got %0h expected 0", v); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL postreset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_regs();
        logic [WIDTH-1:0] v, d, c;
        quiesce();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            wr(ADDR_PRESET, d);
            rd(ADDR_PRESET, v);
            total++;
            if (v !== d) begin bad++; $display("FAIL regs_preset: got %0h expected %0h", v, d); end
            c = $urandom & 32'hFFFF_FFFE;
            wr(ADDR_CTRL, c);
            rd(ADDR_CTRL, v);
            total++;
            if (v !== (c & 32'hF)) begin bad++; $display("FAIL regs_ctrl: got %0h expected %0h", v, c & 32'hF); end
            total++;
            if (irq !== 1'b0) begin bad++; $display("FAIL regs_irq: got %b expected 0", irq); end
        end
    endtask

    task automatic test_oneshot(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] v;
        int t0, e;
        quiesce();
        e = eff(n);
        wr(ADDR_PRESET, n);
        wr(ADDR_CTRL, 32'h9);
        t0 = cyc;
        for (int t = 1; t <= e + 5; t++) begin
            tick();
            if (t >= 2) begin
                rd(ADDR_COUNT, v);
                total++;
                if (v !== run_count(n, t - 2)) begin
                    bad++; $display("FAIL oneshot_count n=%0d t=%0d: got %0d expected %0d", n, t, v, run_count(n, t - 2));
                end
            end
            total++;
            if (irq !== (t >= e + 2)) begin
                bad++; $display("FAIL oneshot_irq n=%0d t=%0d: got %b expected %b", n, t, irq, t >= e + 2);
            end
            rd(ADDR_CTRL, v);
            total++;
            if (v !== ((t >= e + 3) ? 32'h8 : 32'h9)) begin
                bad++; $display("FAIL oneshot_ctrl n=%0d t=%0d: got %0h expected %0h", n, t, v, (t >= e + 3) ? 8 : 9);
            end
        end
        wr(ADDR_PRESET, n);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_clear: got %b expected 0", irq); end
    endtask

    task automatic test_reload(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] v, exp_c;
        int t0, e, p, u;
        quiesce();
        e = eff(n);
        p = e + 2;
        wr(ADDR_PRESET, n);
        wr(ADDR_CTRL, 32'hB);
        t0 = cyc;
        tick();
        for (int t = 2; t <= 3 * p + 2; t++) begin
            tick();
            u = (t - 2) % p;
            exp_c = (u == 0) ? n : (u <= e) ? WIDTH'(e - u) : '0;
            rd(ADDR_COUNT, v);
            total++;
            if (v !== exp_c) begin bad++; $display("FAIL reload_count n=%0d t=%0d: got %0d expected %0d", n, t, v, exp_c); end
            total++;
            if (irq !== (u == e)) begin bad++; $display("FAIL reload_irq n=%0d t=%0d: got %b expected %b", n, t, irq, u == e); end
        end
        quiesce();
    endtask

    task automatic test_mask();
        logic [WIDTH-1:0] v;
        quiesce();
        wr(ADDR_PRESET, 0);
        wr(ADDR_CTRL, 32'h1);
        for (int t = 1; t <= 6; t++) begin
            tick();
            total++;
            if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq t=%0d: got %b expected 0", t, irq); end
            if (t >= 2) begin
                rd(ADDR_COUNT, v);
                total++;
                if (v !== '0) begin bad++; $display("FAIL mask_count t=%0d: got %0d expected 0", t, v); end
            end
            rd(ADDR_CTRL, v);
            total++;
            if (v !== ((t >= 4) ? 32'h0 : 32'h1)) begin bad++; $display("FAIL mask_ctrl t=%0d: got %0h expected %0h", t, v, (t >= 4) ? 0 : 1); end
        end
        wr(ADDR_CTRL, 32'h8);
        repeat (2) begin
            tick();
            total++;
            if (irq !== 1'b0) begin bad++; $display("FAIL mask_unmask_irq: got %b expected 0", irq); end
        end
    endtask

    task automatic test_freeze();
        logic [WIDTH-1:0] v, p;
        int t0;
        quiesce();
        p = $urandom_range(10, 20);
        wr(ADDR_PRESET, p);
        wr(ADDR_CTRL, 32'h1);
        t0 = cyc;
        while (cyc < t0 + 2 + int'(p) - 7) tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== 7) begin bad++; $display("FAIL freeze_at7: got %0d expected 7", v); end
        wr(ADDR_CTRL, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            rd(ADDR_COUNT, v);
            total++;
            if (v !== 6) begin bad++; $display("FAIL freeze_hold: got %0d expected 6", v); end
        end
        wr(ADDR_COUNT, 32'hFFFF);
        rd(ADDR_COUNT, v);
        total++;
        if (v !== 6) begin bad++; $display("FAIL count_write_ignored: got %0d expected 6", v); end
        wr(ADDR_UNUSED, $urandom);
        rd(ADDR_UNUSED, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL unused_reads0: got %0h expected 0", v); end
        rd(ADDR_COUNT, v);
        total++;
        if (v !== 6) begin bad++; $display("FAIL unused_write_count: got %0d expected 6", v); end

        // Re-enable reloads from PRESET; a PRESET write mid-count is deferred
        wr(ADDR_CTRL, 32'h1);
        t0 = cyc;
        while (cyc < t0 + 2) tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== p) begin bad++; $display("FAIL reenable_reload: got %0d expected %0d", v, p); end
        while (cyc < t0 + 4) tick();
        wr(ADDR_PRESET, 9);
        tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== run_count(p, cyc - t0 - 2)) begin
            bad++; $display("FAIL preset_midcount: got %0d expected %0d", v, run_count(p, cyc - t0 - 2));
        end
        rd(ADDR_PRESET, v);
        total++;
        if (v !== 9) begin bad++; $display("FAIL preset_readback: got %0d expected 9", v); end
        quiesce();
    endtask

    task automatic test_back_to_back(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] v;
        int t0, e;
        quiesce();
        e = eff(n);
        wr(ADDR_PRESET, n);
        wr(ADDR_CTRL, 32'h9);
        t0 = cyc;
        while (cyc < t0 + e + 2) tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL b2b_irq_set: got %b expected 1", irq); end
        // This write lands on the same edge the FSM would clear EN
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_CTRL, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("FAIL b2b_cpu_wins: got %0h expected 1", v); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL b2b_irq_clr: got %b expected 0", irq); end
        tick();
        tick();
        rd(ADDR_COUNT, v);
        total++;
        if (v !== n) begin bad++; $display("FAIL b2b_restart: got %0d expected %0d", v, n); end
        quiesce();
    endtask

    task automatic test_set_wins(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] v;
        int t0, e;
        quiesce();
        e = eff(n);
        wr(ADDR_PRESET, n);
        wr(ADDR_CTRL, 32'h9);
        t0 = cyc;
        while (cyc < t0 + e + 1) tick();
        wr(ADDR_PRESET, n);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL setwins_irq: got %b expected 1", irq); end
        tick();
        tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL setwins_hold: got %b expected 1", irq); end
        rd(ADDR_CTRL, v);
        total++;
        if (v !== 32'h8) begin bad++; $display("FAIL setwins_ctrl: got %0h expected 8", v); end
        wr(ADDR_CTRL, 32'h8);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL setwins_clear: got %b expected 0", irq); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_oneshot(3);
        repeat (3) test_oneshot($urandom_range(0, 8));
        test_reload(2);
        repeat (2) test_reload($urandom_range(0, 6));
        test_mask();
        test_freeze();
        test_back_to_back($urandom_range(1, 5));
        test_set_wins($urandom_range(0, 5));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
Memory-mapped programmable countdown timer. It sits downstream of the CPU data port via the system bridge, in the 16-byte windows at 0x7f00 and 0x7f10; two instances are built. Its irq output feeds upstream into one bit of the CPU HWInt bus. The block counts down from a preset value and raises an interrupt at zero, in either one-shot or auto-reload mode.

Parameters:
WIDTH, 32, width of the PRESET and COUNT registers and of the data bus.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
addr  input  2  word offset inside the window (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
we  input  1  write strobe, word write only. The bridge asserts it only when the CPU writes to this window with Req=0.
wdata  input  WIDTH  write data.
rdata  output  WIDTH  combinational read data of the register selected by addr.
irq  output  1  interrupt request to CPU HWInt.

Behaviour:
Registers
- CTRL[3:0]: bit0 EN, bits[2:1] MODE, bit3 IM (interrupt mask, 1 = irq enabled).
- CTRL[WIDTH-1:4] read as 0 and ignore writes.
- MODE 0 = one-shot; MODE 1 = auto-reload; MODE 2 and 3 behave as MODE 0.
- PRESET: full-width read/write.
- COUNT: read-only; writes to offset 2 or 3 are ignored.
- Offset 3 reads 0.

Reset
- Asynchronous clear of CTRL, PRESET, COUNT and pending.
- State = IDLE; irq = 0; rdata reflects the cleared registers.

Output
- irq = pending & CTRL.IM, combinational from registered state.

State machine (IDLE, LOAD, CNT, INT; 2-bit encoding):
- IDLE: when EN=1, go to LOAD next cycle. Otherwise stay, COUNT holds.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If EN=0, go to IDLE with COUNT frozen.
  - Else if COUNT>1, COUNT <= COUNT-1 and stay.
  - Else (COUNT is 1 or 0), COUNT <= 0, set pending, go to INT.
- INT:
  - MODE 1: clear pending; if EN=1 go to LOAD, else go to IDLE.
  - Otherwise: clear CTRL.EN, go to IDLE; pending stays set.

Timing
- PRESET=N≥1 and EN written at edge 0 gives: LOAD at edge 1, COUNT=N at edge 2, COUNT=0 and INT at edge N+2.
- irq goes high after edge N+2.
- PRESET=0 behaves as N=1.
- MODE 1 period is N+2 cycles; irq is a one-cycle pulse at each zero.

Pending clear
- One-shot pending (and therefore irq) stays high until any write to CTRL or PRESET clears it.
- A write in the same cycle as pending-set: set wins.

Simultaneous events
- A CPU write to CTRL in the same cycle the FSM clears EN (INT, one-shot): the CPU value wins.
- The FSM evaluates EN from the registered value, so a write takes effect one cycle later.
- A PRESET write during CNT does not alter the running COUNT; it applies at the next LOAD.
- Clearing EN during LOAD: LOAD still completes, then CNT sees EN=0 and goes to IDLE.
- Clearing IM masks irq immediately but does not clear pending; setting IM again re-exposes it.
- Reset mid-count aborts to the reset state with no irq.

Decomposition:
- Shared define include (same file as the existing opcode/ExcCode defines) holds:
  - register offsets (CTRL/PRESET/COUNT);
  - CTRL bit positions;
  - MODE encodings;
  - FSM state encodings;
  - window base addresses 0x7f00/0x7f10.
- No sub-module: a single FSM plus register file is natural.

Test Plan:
- Reset asserted mid-count (COUNT=5, EN=1) -> next cycle all registers read 0, state IDLE, irq=0.
- PRESET=3, CTRL=0x9 (one-shot, IM=1) -> COUNT reads 3,2,1 on edges 2–4; at edge 5 COUNT=0 and irq=1; CTRL reads 0x8; irq stays high until a PRESET write clears it.
- PRESET=2, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses exactly 4 cycles apart; COUNT sequence 2,1,0,(reload)2,...
- PRESET=0, CTRL=0x1 (IM=0) -> INT reached at edge 3, irq stays 0; then writing CTRL=0x8 (IM=1, EN=0) clears pending, so irq stays 0.
- During CNT at COUNT=7, write CTRL=0x0 -> COUNT freezes at 6; re-enable -> reload from PRESET. Separately, a PRESET write to 9 mid-count leaves the current countdown unchanged.
- Write to offset 2 with 0xFFFF and read offset 3 -> COUNT unchanged; offset 3 reads 0.
